// File: rtl/a2bus_if.sv
// rtl/a2bus_if.sv - Apple II bus snoop signals seen by SoC-side peripherals
interface a2bus_if;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n;
  logic        data_in_strobe;

  modport slave  (input  addr, data, rw_n, data_in_strobe);
  modport master (output addr, data, rw_n, data_in_strobe);
endinterface

// File: rtl/picosoc_a2_mailbox.sv
// rtl/picosoc_a2_mailbox.sv - Apple II command/data byte mailbox drained by PicoSoC firmware
// Optional MAILBOX_IRQ_EN: registered level irq while the FIFO holds entries.
module picosoc_a2_mailbox #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] CMD_ADDR   = 16'hC7FF,
  parameter logic [15:0] DATA_ADDR  = 16'hC7FE
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  a2bus_if.slave      a2bus_if,
  output logic        irq
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = (DEPTH_LOG2)'(1);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_POP      = 3'd1;
  localparam logic [2:0] REG_PEEK     = 3'd2;
  localparam logic [2:0] REG_DROPPED  = 3'd3;
  localparam logic [2:0] REG_LAST_CMD = 3'd4;

  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic [7:0]            dropped;
  logic [7:0]            last_cmd;

  logic        accept, is_write, not_empty, full;
  logic [2:0]  sel;
  logic        pop_en, flush, clr_ovf, clr_drop;
  logic        a2_hit, a2_tag, push_en, drop_en;
  logic [8:0]  head;
  logic [8:0]  count_ext;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign accept    = iomem_valid & ~iomem_ready;
  assign is_write  = |iomem_wstrb;
  assign sel       = iomem_addr[4:2];
  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign head      = mem[rd_ptr];
  assign count_ext = 9'(count);

  assign pop_en   = accept & ~is_write & (sel == REG_POP) & not_empty;
  assign flush    = accept & is_write & (sel == REG_STATUS) & iomem_wdata[0];
  assign clr_ovf  = accept & is_write & (sel == REG_STATUS) & iomem_wdata[2];
  assign clr_drop = accept & is_write & (sel == REG_DROPPED);

  assign a2_tag  = (a2bus_if.addr == CMD_ADDR);
  assign a2_hit  = a2bus_if.data_in_strobe & ~a2bus_if.rw_n &
                   (a2_tag | (a2bus_if.addr == DATA_ADDR));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_en = a2_hit & ~flush & (~full | pop_en);
  assign drop_en = a2_hit & ~flush & full & ~pop_en;

  assign unused_bits = ^{iomem_addr[31:5], iomem_addr[1:0], iomem_wdata[31:3],
                         iomem_wdata[1], count_ext[8]};

  always_comb begin
    rd_val = '0;
    if (!is_write) begin
      case (sel)
        REG_STATUS:       rd_val = {16'b0, count_ext[7:0], 5'b0, overflow, full, not_empty};
        REG_POP, REG_PEEK: if (not_empty) rd_val = {1'b1, 22'b0, head};
        REG_DROPPED:      rd_val = {24'b0, dropped};
        REG_LAST_CMD:     rd_val = {24'b0, last_cmd};
        default:          rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      dropped     <= '0;
      last_cmd    <= '0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= accept ? rd_val : '0;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (push_en && !pop_en)      count <= count + CNT_ONE;
        else if (pop_en && !push_en) count <= count - CNT_ONE;
      end

      // Setting on a dropped push takes priority over a firmware clear.
      if (drop_en)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;

      if (clr_drop)                        dropped <= {7'b0, drop_en};
      else if (drop_en && dropped != 8'hFF) dropped <= dropped + 8'd1;

      if (push_en && a2_tag) last_cmd <= a2bus_if.data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= {a2_tag, a2bus_if.data};
  end

`ifdef MAILBOX_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= not_empty;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_picosoc_a2_mailbox.sv
// tb/tb_picosoc_a2_mailbox.sv - randomized self-checking bench for picosoc_a2_mailbox
module tb_picosoc_a2_mailbox;
  localparam int          DL    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] CMD   = 16'hC7FF;
  localparam logic [15:0] DATA  = 16'hC7FE;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;
  logic        irq;

  a2bus_if a2 ();

  picosoc_a2_mailbox #(.DEPTH_LOG2(DL), .CMD_ADDR(CMD), .DATA_ADDR(DATA)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .iomem_ready(iomem_ready), .a2bus_if(a2), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference model: FIFO as a queue of {tag, byte}.
  bit [8:0] q[$];
  bit       ovf = 1'b0;
  int       dropped = 0;
  bit [7:0] last_cmd = 8'h00;

  function automatic logic [31:0] exp_read(input bit [2:0] r);
    case (r)
      3'd0: return {16'b0, 8'(q.size()), 5'b0, ovf, q.size() == DEPTH, q.size() != 0};
      3'd1, 3'd2: return (q.size() != 0) ? {1'b1, 22'b0, q[0]} : 32'h0;
      3'd3: return 32'(dropped);
      3'd4: return {24'b0, last_cmd};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_cycle(input bit io_en, input bit wr, input bit [2:0] r,
                                  input bit [31:0] wd, input bit a2_en, input bit [15:0] a,
                                  input bit [7:0] d, input bit rw_n);
    bit flushed = 1'b0;
    if (io_en) begin
      if (wr && r == 3'd0) begin
        if (wd[0]) begin q.delete(); flushed = 1'b1; end
        if (wd[2]) ovf = 1'b0;
      end else if (wr && r == 3'd3) dropped = 0;
      else if (!wr && r == 3'd1 && q.size() != 0) void'(q.pop_front());
    end
    if (a2_en && !rw_n && (a == CMD || a == DATA) && !flushed) begin
      if (q.size() < DEPTH) begin
        q.push_back({a == CMD, d});
        if (a == CMD) last_cmd = d;
      end else begin
        ovf = 1'b1;
        if (dropped < 255) dropped++;
      end
    end
  endfunction

  // One bus cycle with optional SoC access and Apple II strobe; ends one idle cycle after ready.
  task automatic cycle(input bit io_en, input bit wr, input bit [2:0] r, input bit [31:0] wd,
                       input bit a2_en, input bit [15:0] a, input bit [7:0] d, input bit rw_n,
                       output logic [31:0] rd);
    int n;
    iomem_valid = io_en;
    iomem_wstrb = (io_en && wr) ? 4'hF : 4'h0;
    iomem_addr  = {27'b0, r, 2'b0};
    iomem_wdata = wd;
    a2.addr = a; a2.data = d; a2.rw_n = rw_n; a2.data_in_strobe = a2_en;
    @(posedge clk);
    m_cycle(io_en, wr, r, wd, a2_en, a, d, rw_n);
    #1;
    a2.data_in_strobe = 1'b0;
    a2.rw_n = 1'b1;
    rd = '0;
    if (io_en) begin
      n = 0;
      while (!iomem_ready && n < 4) begin @(posedge clk); #1; n++; end
      total++;
      if (!iomem_ready) $display("FAIL ready_timeout ready=0 required=1");
      else passed++;
      rd = iomem_rdata;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
      @(posedge clk); #1;
    end
  endtask

  task automatic a2w(input bit [15:0] a, input bit [7:0] d);
    logic [31:0] rd;
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, a, d, 1'b0, rd);
  endtask

  task automatic io(input bit wr, input bit [2:0] r, input bit [31:0] wd, output logic [31:0] rd);
    cycle(1'b1, wr, r, wd, 1'b0, 16'h0, 8'h0, 1'b1, rd);
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    a2.addr = '0; a2.data = '0; a2.rw_n = 1'b1; a2.data_in_strobe = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (iomem_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", iomem_ready); else passed++;
    total++; if (iomem_rdata !== 32'h0) $display("FAIL reset_rdata got=%h want=0", iomem_rdata); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b want=0", irq); else passed++;
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 5; r++) begin
      io(1'b0, 3'(r), 32'h0, rd);
      total++; if (rd !== 32'h0) $display("FAIL reset_reg%0d got=%h want=0", r, rd); else passed++;
    end
  endtask

  task automatic test_push_pop;
    logic [31:0] rd, e;
    a2w(DATA, 8'h42);
    a2w(CMD, 8'h91);
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd[15:8] !== 8'd2) $display("FAIL pp_count got=%0d want=2", rd[15:8]); else passed++;
    io(1'b0, 3'd1, 32'h0, rd);
    total++; if (rd !== 32'h8000_0042) $display("FAIL pp_pop1 got=%h want=80000042", rd); else passed++;
    io(1'b0, 3'd1, 32'h0, rd);
    total++; if (rd !== 32'h8000_0191) $display("FAIL pp_pop2 got=%h want=80000191", rd); else passed++;
    io(1'b0, 3'd1, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL pp_pop_empty got=%h want=0", rd); else passed++;
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd[0] !== 1'b0) $display("FAIL pp_not_empty got=%b want=0", rd[0]); else passed++;
    e = exp_read(3'd4);
    io(1'b0, 3'd4, 32'h0, rd);
    total++; if (rd !== e) $display("FAIL pp_last_cmd got=%h want=%h", rd, e); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] rd, e, wd;
    bit [15:0] a;
    bit [2:0]  r;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          case ($urandom_range(0, 3))
            0: a = CMD;
            1: a = DATA;
            2: a = 16'hC7FD;
            default: a = 16'($urandom);
          endcase
          cycle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, a, 8'($urandom), 1'($urandom_range(0, 3) == 0), rd);
        end
        2: begin
          r = 3'($urandom_range(0, 7));
          e = exp_read(r);
          io(1'b0, r, 32'h0, rd);
          total++; if (rd !== e) $display("FAIL rand_read reg=%0d got=%h want=%h", r, rd, e); else passed++;
        end
        default: begin
          r = 3'($urandom_range(0, 7));
          wd = $urandom;
          if ($urandom_range(0, 7) != 0) wd[0] = 1'b0;
          io(1'b1, r, wd, rd);
        end
      endcase
    end
    while (q.size() != 0) begin
      e = exp_read(3'd1);
      io(1'b0, 3'd1, 32'h0, rd);
      total++; if (rd !== e) $display("FAIL rand_drain got=%h want=%h", rd, e); else passed++;
    end
    io(1'b1, 3'd0, 32'h4, rd);
    io(1'b1, 3'd3, 32'h0, rd);
  endtask

  task automatic test_overflow;
    logic [31:0] rd, e;
    for (int i = 0; i < DEPTH + 2; i++) a2w(DATA, 8'($urandom));
    e = exp_read(3'd0);
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== e || rd[15:8] !== 8'(DEPTH) || rd[2:1] !== 2'b11)
      $display("FAIL ovf_status got=%h want=%h", rd, e); else passed++;
    io(1'b0, 3'd3, 32'h0, rd);
    total++; if (rd !== 32'd2) $display("FAIL ovf_dropped got=%0d want=2", rd); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_read(3'd1);
      io(1'b0, 3'd1, 32'h0, rd);
      total++; if (rd !== e) $display("FAIL ovf_pop%0d got=%h want=%h", i, rd, e); else passed++;
    end
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== 32'h4) $display("FAIL ovf_sticky got=%h want=00000004", rd); else passed++;
    io(1'b1, 3'd0, 32'h4, rd);
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL ovf_clear got=%h want=0", rd); else passed++;
    io(1'b1, 3'd3, 32'h0, rd);
    io(1'b0, 3'd3, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL dropped_clear got=%h want=0", rd); else passed++;
  endtask

  task automatic test_push_during_pop_full;
    logic [31:0] rd, e;
    bit [7:0] nb;
    for (int i = 0; i < DEPTH; i++) a2w(DATA, 8'($urandom));
    nb = 8'($urandom);
    e = exp_read(3'd1);
    cycle(1'b1, 1'b0, 3'd1, 32'h0, 1'b1, CMD, nb, 1'b0, rd);
    total++; if (rd !== e) $display("FAIL pdp_pop got=%h want=%h", rd, e); else passed++;
    e = exp_read(3'd0);
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== e || rd[2] !== 1'b0) $display("FAIL pdp_status got=%h want=%h", rd, e); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_read(3'd1);
      io(1'b0, 3'd1, 32'h0, rd);
      total++; if (rd !== e) $display("FAIL pdp_drain%0d got=%h want=%h", i, rd, e); else passed++;
    end
    total++; if (rd !== {1'b1, 22'b0, 1'b1, nb}) $display("FAIL pdp_last got=%h want=%h", rd, {1'b1, 22'b0, 1'b1, nb}); else passed++;
  endtask

  task automatic test_flush_race;
    logic [31:0] rd, e;
    for (int i = 0; i < 3; i++) a2w(DATA, 8'($urandom));
    cycle(1'b1, 1'b1, 3'd0, 32'h1, 1'b1, DATA, 8'hA5, 1'b0, rd);
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL flush_status got=%h want=0", rd); else passed++;
    io(1'b0, 3'd3, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL flush_dropped got=%h want=0", rd); else passed++;
    for (int i = 0; i < DEPTH; i++) a2w(CMD, 8'($urandom));
    cycle(1'b1, 1'b1, 3'd0, 32'h4, 1'b1, DATA, 8'h5A, 1'b0, rd);
    e = exp_read(3'd0);
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== e || rd[2] !== 1'b1) $display("FAIL ovf_race got=%h want=%h", rd, e); else passed++;
    e = exp_read(3'd3);
    io(1'b0, 3'd3, 32'h0, rd);
    total++; if (rd !== e) $display("FAIL ovf_race_dropped got=%h want=%h", rd, e); else passed++;
    io(1'b1, 3'd0, 32'h5, rd);
    io(1'b1, 3'd3, 32'h0, rd);
  endtask

  task automatic test_handshake;
    logic [31:0] rd, e, got;
    int pulses = 0;
    a2w(DATA, 8'h11);
    a2w(CMD, 8'h22);
    e = exp_read(3'd1);
    got = '0;
    iomem_valid = 1'b1; iomem_wstrb = 4'h0; iomem_addr = {27'b0, 3'd1, 2'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (i == 0) m_cycle(1'b1, 1'b0, 3'd1, 32'h0, 1'b0, 16'h0, 8'h0, 1'b1);
      #1;
      if (iomem_ready) begin pulses++; got = iomem_rdata; end
      else begin
        total++; if (iomem_rdata !== 32'h0) $display("FAIL hs_idle_rdata got=%h want=0", iomem_rdata); else passed++;
      end
      if (i == 1) iomem_valid = 1'b0;
    end
    total++; if (pulses != 1) $display("FAIL hs_pulses got=%0d want=1", pulses); else passed++;
    total++; if (got !== e) $display("FAIL hs_data got=%h want=%h", got, e); else passed++;
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd[15:8] !== 8'd1) $display("FAIL hs_count got=%0d want=1", rd[15:8]); else passed++;
    io(1'b1, 3'd0, 32'h1, rd);
  endtask

  task automatic test_wrap_irq;
    logic [31:0] rd, e;
    bit tag;
    for (int i = 0; i < 20; i++) begin
      tag = 1'($urandom);
      a2w(tag ? CMD : DATA, 8'($urandom));
      e = exp_read(3'd1);
      io(1'b0, 3'd1, 32'h0, rd);
      total++; if (rd !== e) $display("FAIL wrap%0d got=%h want=%h", i, rd, e); else passed++;
`ifdef MAILBOX_IRQ_EN
      total++; if (irq !== (q.size() != 0)) $display("FAIL wrap_irq%0d got=%b want=%b", i, irq, q.size() != 0); else passed++;
`else
      total++; if (irq !== 1'b0) $display("FAIL wrap_irq%0d got=%b want=0", i, irq); else passed++;
`endif
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd;
    a2w(DATA, 8'h33);
    a2w(DATA, 8'h44);
    iomem_valid = 1'b1; iomem_wstrb = 4'h0; iomem_addr = {27'b0, 3'd1, 2'b0};
    resetn = 1'b0;
    @(posedge clk); #1;
    total++; if (iomem_ready !== 1'b0) $display("FAIL abort_ready got=%b want=0", iomem_ready); else passed++;
    iomem_valid = 1'b0;
    q.delete(); ovf = 1'b0; dropped = 0; last_cmd = 8'h00;
    resetn = 1'b1;
    @(posedge clk); #1;
    io(1'b0, 3'd0, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL abort_status got=%h want=0", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_push_during_pop_full();
    test_flush_race();
    test_handshake();
    test_wrap_irq();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
